// File: rtl/vga_rx_pkg.sv
// vga_rx_pkg: timing defaults, lock states and alarm classes shared by the VGA alarm decoder
package vga_rx_pkg;
  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_BOTTOM  = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_TOP     = 33;
  localparam int DEF_H_TOTAL   = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int DEF_V_TOTAL   = DEF_V_DISPLAY + DEF_V_BOTTOM + DEF_V_SYNC + DEF_V_TOP;
  typedef enum logic [1:0] {UNLOCKED, H_LOCK, LOCKED} lock_state_t;
  typedef enum logic [1:0] {NONE, INTRUSION, WINDOW, TEMP} alarm_code_t;
  function automatic logic [2:0] classify(input logic [5:0] c);
    return c == 6'h3F ? {1'b1, TEMP} : c == 6'h3C ? {1'b1, WINDOW} :
           c == 6'h33 ? {1'b1, INTRUSION} : {c == 6'h00, NONE};
  endfunction
endpackage

// File: rtl/vga_alarm_decoder_if.sv
// vga_alarm_decoder_if: TinyVGA input plus decoded pixel/alarm outputs
interface vga_alarm_decoder_if;
  logic [7:0] vga_in;
  logic       locked;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       pix_valid;
  logic [5:0] color;
  logic [1:0] alarm_code;
  logic       alarm_valid;
  logic       alarm_mixed;
  logic [7:0] frame_count;
  logic       sync_err;
  logic       blank_err;
  modport master (output vga_in, input locked, pix_x, pix_y, pix_valid, color, alarm_code,
                  alarm_valid, alarm_mixed, frame_count, sync_err, blank_err);
  modport slave  (input vga_in, output locked, pix_x, pix_y, pix_valid, color, alarm_code,
                  alarm_valid, alarm_mixed, frame_count, sync_err, blank_err);
endinterface

// File: rtl/vga_timing_tracker.sv
// vga_timing_tracker: recovers pixel x/y and sync edges from the captured sample stream
module vga_timing_tracker import vga_rx_pkg::*; #(
  parameter int H_TOTAL = DEF_H_TOTAL,
  parameter int V_TOTAL = DEF_V_TOTAL,
  parameter int HS_X    = DEF_H_DISPLAY + DEF_H_FRONT,
  parameter int VS_Y    = DEF_V_DISPLAY + DEF_V_BOTTOM
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hsync,
  input  logic       vsync,
  output logic       hs_fall,
  output logic       vs_fall,
  output logic       h_period_ok,
  output logic [9:0] x_pred,
  output logic [9:0] y_pred,
  output logic [9:0] x_nxt,
  output logic [9:0] y_nxt,
  output logic [9:0] x,
  output logic [9:0] y
);
  localparam logic [9:0]  X_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  Y_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  HS_POS   = 10'(HS_X);
  localparam logic [9:0]  VS_POS   = 10'(VS_Y);
  localparam logic [11:0] H_PERIOD = 12'(H_TOTAL - 1);
  logic hs_q, vs_q, x_wrap;
  logic [11:0] hcnt;
  // edge detect against the previous sample and predict the next coordinate
  always_comb begin
    hs_fall = hs_q && !hsync;
    vs_fall = vs_q && !vsync;
    x_wrap = x == X_LAST;
    x_pred = x_wrap ? '0 : x + 10'd1;
    y_pred = !x_wrap ? y : y == Y_LAST ? '0 : y + 10'd1;
    x_nxt = hs_fall ? HS_POS : x_pred;
    y_nxt = vs_fall ? VS_POS : hs_fall ? y : y_pred;
    h_period_ok = hs_fall && hcnt == H_PERIOD;
  end
  // coordinate registers and saturating hsync period counter (saturated = no prior edge)
  always_ff @(posedge clk) begin
    if (reset) begin
      hs_q <= 1'b1;
      vs_q <= 1'b1;
      x <= '0;
      y <= '0;
      hcnt <= '1;
    end else begin
      hs_q <= hsync;
      vs_q <= vsync;
      x <= x_nxt;
      y <= y_nxt;
      hcnt <= hs_fall ? '0 : &hcnt ? hcnt : hcnt + 12'd1;
    end
  end
endmodule

// File: rtl/vga_alarm_decoder.sv
// vga_alarm_decoder: locks to TinyVGA timing and classifies each full frame into an alarm code
module vga_alarm_decoder import vga_rx_pkg::*; #(
  parameter int H_DISPLAY = DEF_H_DISPLAY,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_DISPLAY = DEF_V_DISPLAY,
  parameter int V_BOTTOM  = DEF_V_BOTTOM,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_TOP     = DEF_V_TOP
) (
  input logic clk,
  input logic reset,
  vga_alarm_decoder_if.slave bus
);
  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;
  localparam logic [9:0] HS_POS = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] VS_POS = 10'(V_DISPLAY + V_BOTTOM);
  localparam logic [9:0] XD = 10'(H_DISPLAY);
  localparam logic [9:0] YD = 10'(V_DISPLAY);
  localparam logic [9:0] X_LAST = 10'(H_DISPLAY - 1);
  localparam logic [9:0] Y_LAST = 10'(V_DISPLAY - 1);
  logic [7:0] vin;
  lock_state_t state, state_nxt;
  logic hs_fall, vs_fall, h_period_ok;
  logic [9:0] x_pred, y_pred, x_nxt, y_nxt;
  logic h_bad, v_bad, err, lock_nxt, active, first, take, strobe, ok, m_nxt, full, acc_mixed;
  logic [1:0] cls, c_nxt, acc_cls;
  logic [5:0] col;
  vga_timing_tracker #(
    .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL),
    .HS_X(H_DISPLAY + H_FRONT), .VS_Y(V_DISPLAY + V_BOTTOM)
  ) u_trk (
    .clk(clk), .reset(reset), .hsync(vin[7]), .vsync(vin[3]),
    .hs_fall(hs_fall), .vs_fall(vs_fall), .h_period_ok(h_period_ok),
    .x_pred(x_pred), .y_pred(y_pred), .x_nxt(x_nxt), .y_nxt(y_nxt),
    .x(bus.pix_x), .y(bus.pix_y)
  );
  // single input capture; reset value means syncs idle and black
  always_ff @(posedge clk) begin
    vin <= reset ? 8'h88 : bus.vga_in;
  end
  // lock state register
  always_ff @(posedge clk) begin
    state <= reset ? UNLOCKED : state_nxt;
  end
  // lock transitions, sync checking and per-sample frame accumulation
  always_comb begin
    col = {vin[0], vin[4], vin[1], vin[5], vin[2], vin[6]};
    {ok, cls} = classify(col);
    h_bad = hs_fall ? x_pred != HS_POS : x_pred == HS_POS;
    v_bad = vs_fall && y_pred != VS_POS;
    err = state != UNLOCKED && (h_bad || (state == LOCKED && v_bad));
    state_nxt = err ? UNLOCKED :
                state == UNLOCKED ? (h_period_ok ? H_LOCK : UNLOCKED) :
                state == H_LOCK ? (vs_fall ? LOCKED : H_LOCK) : LOCKED;
    lock_nxt = state_nxt == LOCKED;
    active = x_nxt < XD && y_nxt < YD;
    first = x_nxt == '0 && y_nxt == '0;
    take = lock_nxt && active && (full || first);
    strobe = take && x_nxt == X_LAST && y_nxt == Y_LAST;
    m_nxt = first ? !ok : acc_mixed || !ok || cls != acc_cls;
    c_nxt = first ? cls : acc_cls;
  end
  // frame accumulator; only frames whose first active sample was seen while locked count
  always_ff @(posedge clk) begin
    if (reset || !lock_nxt || strobe) begin
      full <= 1'b0;
      acc_mixed <= 1'b0;
      acc_cls <= NONE;
    end else if (take) begin
      full <= 1'b1;
      acc_mixed <= m_nxt;
      acc_cls <= c_nxt;
    end
  end
  // registered decoded outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.pix_valid <= 1'b0;
      bus.color <= '0;
      bus.alarm_valid <= 1'b0;
      bus.alarm_code <= NONE;
      bus.alarm_mixed <= 1'b0;
      bus.frame_count <= '0;
      bus.sync_err <= 1'b0;
      bus.blank_err <= 1'b0;
    end else begin
      bus.pix_valid <= lock_nxt && active;
      bus.color <= col;
      bus.alarm_valid <= strobe;
      bus.alarm_code <= strobe && !m_nxt ? c_nxt : NONE;
      bus.alarm_mixed <= strobe && m_nxt;
      bus.frame_count <= bus.frame_count + {7'd0, strobe};
      bus.sync_err <= err;
      bus.blank_err <= lock_nxt && !active && col != '0;
    end
  end
  assign bus.locked = state == LOCKED;
endmodule

// File: tb/tb_vga_alarm_decoder.sv
// tb_vga_alarm_decoder: directed frame-level checks on a reduced-size VGA timing
module tb_vga_alarm_decoder;
  localparam int HD = 32, HF = 4, HS = 8, HB = 4, HT = HD + HF + HS + HB;
  localparam int VD = 12, VB = 2, VS = 2, VT = 4, VTT = VD + VB + VS + VT;
  logic clk = 1'b0;
  logic rst = 1'b1;
  vga_alarm_decoder_if bus();
  vga_alarm_decoder #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_BOTTOM(VB), .V_SYNC(VS), .V_TOP(VT)
  ) dut (.clk(clk), .reset(rst), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  int gx = 0, gy = 0, px = 0, py = 0;
  int n_alarm = 0, n_serr = 0, n_berr = 0, n_unl = 0, n_bad = 0;
  int lcode = 0, lmixed = 0, lfc = 0;
  logic prev_rst = 1'b1;
  logic [5:0] prev_col = '0;
  logic [5:0] active_col = 6'h3F;
  logic mag_en = 1'b0, blank_en = 1'b0, shift_en = 1'b0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [5:0] gcol(input int x, input int y);
    logic [5:0] c;
    c = (x < HD && y < VD) ? active_col : 6'h00;
    if (mag_en && x == HD / 2 && y == 3) c = 6'h33;
    if (blank_en && x == 40 && y == 1) c = 6'h3F;
    return c;
  endfunction
  function automatic logic [7:0] gen(input int x, input int y);
    logic [5:0] c;
    logic hs, vs;
    c = gcol(x, y);
    hs = !(x >= ((shift_en && y == 5) ? HD + HF - 4 : HD + HF) && x < HD + HF + HS);
    vs = !(y >= VD + VB && y < VD + VB + VS);
    return {hs, c[0], c[2], c[4], vs, c[1], c[3], c[5]};
  endfunction
  task automatic step();
    logic [5:0] ec;
    bus.vga_in = gen(gx, gy);
    @(posedge clk);
    #1;
    ec = (rst || prev_rst) ? 6'h00 : prev_col;
    if (bus.color !== ec) n_bad++;
    if (bus.locked) begin
      if (bus.pix_x !== 10'(px) || bus.pix_y !== 10'(py) || bus.pix_valid !== (px < HD && py < VD)) n_bad++;
    end else if (bus.pix_valid !== 1'b0) n_bad++;
    if (!bus.locked) n_unl++;
    if (bus.alarm_valid) begin
      n_alarm++;
      lcode = int'(bus.alarm_code);
      lmixed = int'(bus.alarm_mixed);
      lfc = int'(bus.frame_count);
    end
    n_serr += int'(bus.sync_err);
    n_berr += int'(bus.blank_err);
    prev_col = gcol(gx, gy);
    prev_rst = rst;
    px = gx;
    py = gy;
    gx = gx == HT - 1 ? 0 : gx + 1;
    if (gx == 0) gy = gy == VTT - 1 ? 0 : gy + 1;
  endtask
  task automatic run_frame(input string tag, input int ea, input int ec, input int em,
                           input int efc, input int es, input int eb, input int eu);
    do step(); while (!(gx == 0 && gy == 0));
    chk({tag, "_alarms"}, n_alarm, ea);
    if (ea > 0) begin
      chk({tag, "_code"}, lcode, ec);
      chk({tag, "_mixed"}, lmixed, em);
      chk({tag, "_fcount"}, lfc, efc);
    end
    chk({tag, "_sync_err"}, n_serr, es);
    chk({tag, "_blank_err"}, n_berr, eb);
    chk({tag, "_unlock_seen"}, n_unl > 0, eu);
    chk({tag, "_locked_end"}, bus.locked, 1);
    chk({tag, "_pix_model"}, n_bad, 0);
    n_alarm = 0; n_serr = 0; n_berr = 0; n_unl = 0; n_bad = 0;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_locked"}, bus.locked, 0);
    chk({tag, "_pix_valid"}, bus.pix_valid, 0);
    chk({tag, "_pix_x"}, bus.pix_x, 0);
    chk({tag, "_pix_y"}, bus.pix_y, 0);
    chk({tag, "_color"}, bus.color, 0);
    chk({tag, "_alarm"}, {bus.alarm_valid, bus.alarm_mixed, bus.alarm_code}, 0);
    chk({tag, "_fcount"}, bus.frame_count, 0);
    chk({tag, "_errs"}, {bus.sync_err, bus.blank_err}, 0);
  endtask
  initial begin
    rst = 1'b1;
    repeat (3) step();
    chk_zero("reset");
    rst = 1'b0;
    n_alarm = 0; n_serr = 0; n_berr = 0; n_unl = 0; n_bad = 0;
    run_frame("f0_acquire", 0, 0, 0, 0, 0, 0, 1);
    run_frame("f1_white", 1, 3, 0, 1, 0, 0, 0);
    run_frame("f2_white", 1, 3, 0, 2, 0, 0, 0);
    active_col = 6'h33;
    step();
    step();
    chk("lat_pix_x", bus.pix_x, 0);
    chk("lat_pix_y", bus.pix_y, 0);
    chk("lat_color", bus.color, 6'h33);
    chk("lat_pix_valid", bus.pix_valid, 1);
    run_frame("f3_magenta", 1, 1, 0, 3, 0, 0, 0);
    active_col = 6'h3C;
    mag_en = 1'b1;
    run_frame("f4_yel_mag", 1, 0, 1, 4, 0, 0, 0);
    mag_en = 1'b0;
    run_frame("f5_yellow", 1, 2, 0, 5, 0, 0, 0);
    active_col = 6'h00;
    blank_en = 1'b1;
    run_frame("f6_blank", 1, 0, 0, 6, 0, 1, 0);
    blank_en = 1'b0;
    active_col = 6'h3F;
    shift_en = 1'b1;
    run_frame("f7_shift", 0, 0, 0, 0, 1, 0, 1);
    shift_en = 1'b0;
    run_frame("f8_relock", 1, 3, 0, 7, 0, 0, 0);
    while (!(gx == HD / 2 - 1 && gy == 6)) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_zero("midreset");
    run_frame("f9_reset", 0, 0, 0, 0, 0, 0, 1);
    run_frame("f10_after", 1, 3, 0, 1, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
